// File: rtl/acc_writeback.sv
// acc_writeback: per-lane ReLU / rounded shift / saturation of drained
// accumulator rows, buffered in a first-word-fall-through FIFO and streamed
// out on valid/ready with a frame-end marker.
module acc_writeback #(
  parameter int unsigned ARRAY_M    = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned OUT_WIDTH  = 8,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              in_valid,
  input  logic [ARRAY_M*DATA_WIDTH-1:0]     in_data,
  input  logic                              cfg_relu,
  input  logic [4:0]                        cfg_shift,
  input  logic [$clog2(DEPTH):0]            cfg_num_rows,
  output logic                              space_ok,
  output logic                              overflow,
  output logic                              m_valid,
  input  logic                              m_ready,
  output logic [ARRAY_M*OUT_WIDTH-1:0]      m_data,
  output logic                              m_last
);

  localparam int unsigned LW          = DATA_WIDTH + 1;
  localparam int unsigned PW          = $clog2(FIFO_DEPTH);
  localparam int unsigned CW          = PW + 1;
  localparam int unsigned FW          = $clog2(DEPTH);
  localparam int unsigned RW          = FW + 1;
  localparam int unsigned ROW_W       = ARRAY_M * OUT_WIDTH;
  localparam int unsigned S1_W        = ARRAY_M * LW;
  localparam int unsigned SPACE_LIMIT = FIFO_DEPTH - DEPTH;

  localparam logic signed [LW-1:0] SAT_HI = LW'((2 ** (OUT_WIDTH - 1)) - 1);
  localparam logic signed [LW-1:0] SAT_LO = LW'(-(2 ** (OUT_WIDTH - 1)));

  // ReLU then round-half-up arithmetic right shift, one extra bit of headroom
  function automatic logic signed [LW-1:0] shape_lane(
    input logic signed [DATA_WIDTH-1:0] x,
    input logic                         relu,
    input logic [4:0]                   sh
  );
    logic signed [LW-1:0] v;
    logic signed [LW-1:0] rnd;
    v   = {x[DATA_WIDTH-1], x};
    rnd = '0;
    if (relu && x[DATA_WIDTH-1]) v = '0;
    if (sh != 5'd0) begin
      rnd = LW'(1) << (sh - 5'd1);
      v   = (v + rnd) >>> sh;
    end
    return v;
  endfunction

  // Clamp a shaped lane into the signed output range
  function automatic logic [OUT_WIDTH-1:0] sat_lane(input logic signed [LW-1:0] v);
    logic [OUT_WIDTH-1:0] r;
    if (v > SAT_HI)      r = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    else if (v < SAT_LO) r = {1'b1, {(OUT_WIDTH-1){1'b0}}};
    else                 r = v[OUT_WIDTH-1:0];
    return r;
  endfunction

  logic                 s1_valid;
  logic [S1_W-1:0]      s1_data;
  logic [S1_W-1:0]      shaped;
  logic [ROW_W-1:0]     sat_row;
  logic [ROW_W-1:0]     mem [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [CW-1:0]        count;
  logic [FW-1:0]        frame_cnt;
  logic [RW-1:0]        eff_rows;
  logic                 full;
  logic                 pop;
  logic                 push;

  // Stage 1 combinational lane shaping
  always_comb begin
    shaped = '0;
    for (int unsigned i = 0; i < ARRAY_M; i++) begin
      shaped[i*LW +: LW] = shape_lane(in_data[i*DATA_WIDTH +: DATA_WIDTH], cfg_relu, cfg_shift);
    end
  end

  // Stage 2 saturation of the registered lanes
  always_comb begin
    sat_row = '0;
    for (int unsigned i = 0; i < ARRAY_M; i++) begin
      sat_row[i*OUT_WIDTH +: OUT_WIDTH] = sat_lane(s1_data[i*LW +: LW]);
    end
  end

  assign full     = (count == CW'(FIFO_DEPTH));
  assign pop      = (count != '0) && m_ready;
  // A pop frees the slot, so a push into a full FIFO is accepted in that cycle
  assign push     = s1_valid && (!full || pop);
  assign eff_rows = (cfg_num_rows == '0) ? RW'(DEPTH) : cfg_num_rows;

  assign m_valid  = (count != '0);
  assign m_data   = mem[rd_ptr];
  assign m_last   = m_valid && ({1'b0, frame_cnt} == (eff_rows - RW'(1)));
  // Row still in stage 1 will land in the FIFO, so it is counted as occupied
  assign space_ok = ((CW+1)'(count) + (CW+1)'(s1_valid)) <= (CW+1)'(SPACE_LIMIT);

  // Pipeline register, pointers, occupancy, frame counter and sticky overflow
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s1_data   <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      frame_cnt <= '0;
      overflow  <= 1'b0;
    end else begin
      s1_valid <= in_valid;
      s1_data  <= shaped;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (s1_valid && full && !pop) overflow <= 1'b1;
      if (pop) begin
        if (m_last) frame_cnt <= '0;
        else        frame_cnt <= frame_cnt + FW'(1);
      end
    end
  end

  // FIFO storage; contents are qualified by count so no reset is needed
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= sat_row;
  end

endmodule
